// File: rtl/data_mem_mmio.sv
// Data-memory slave for the core's MEM stage: word RAM, 64-bit machine timer
// with compare interrupt, and a UART transmit FIFO drained by a valid/ready port.
// Reads are combinational and side-effect free; all state changes on posedge clk.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMER_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_data__address,
    input  logic [31:0] memory_data__write_data,
    input  logic [3:0]  memory_data__write_enable,
    output logic [31:0] memory_data__read_data,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    output logic        timer_irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PRE_W  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TIMER_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_MTIME_LO    = 32'h8000_0000;
    localparam logic [31:0] ADDR_MTIME_HI    = 32'h8000_0004;
    localparam logic [31:0] ADDR_MTIMECMP_LO = 32'h8000_0008;
    localparam logic [31:0] ADDR_MTIMECMP_HI = 32'h8000_000C;
    localparam logic [31:0] ADDR_UART_TX     = 32'h8000_0010;
    localparam logic [31:0] ADDR_UART_STATUS = 32'h8000_0014;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]       word_addr_s;
    logic              any_we_s;
    logic              mmio_wr_s;
    logic              ram_hit_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              unused_addr_s;

    assign word_addr_s   = {memory_data__address[31:2], 2'b00};
    assign any_we_s      = |memory_data__write_enable;
    // Register targets ignore stores while reset is asserted; RAM does not.
    assign mmio_wr_s     = any_we_s && !reset;
    assign ram_hit_s     = (memory_data__address[31] == 1'b0) &&
                           (memory_data__address[30:2] < 29'(RAM_WORDS));
    assign ram_idx_s     = memory_data__address[RAM_AW+1:2];
    assign unused_addr_s = ^memory_data__address[1:0];

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] mem_r [RAM_WORDS];

    // Byte-lane RAM write; no reset so contents survive and reset-cycle stores land.
    always_ff @(posedge clk) begin
        if (any_we_s && ram_hit_s) begin
            mem_r[ram_idx_s] <= merge_bytes(mem_r[ram_idx_s],
                                            memory_data__write_data,
                                            memory_data__write_enable);
        end
    end

    // ------------------------------------------------------------------
    // Machine timer
    // ------------------------------------------------------------------
    logic [63:0]      mtime_r;
    logic [63:0]      mtimecmp_r;
    logic [PRE_W-1:0] pre_r;
    logic             irq_r;
    logic             tick_s;
    logic             mt_lo_wr_s;
    logic             mt_hi_wr_s;
    logic             cmp_lo_wr_s;
    logic             cmp_hi_wr_s;

    assign tick_s      = (pre_r == PRE_MAX);
    assign mt_lo_wr_s  = mmio_wr_s && (word_addr_s == ADDR_MTIME_LO);
    assign mt_hi_wr_s  = mmio_wr_s && (word_addr_s == ADDR_MTIME_HI);
    assign cmp_lo_wr_s = mmio_wr_s && (word_addr_s == ADDR_MTIMECMP_LO);
    assign cmp_hi_wr_s = mmio_wr_s && (word_addr_s == ADDR_MTIMECMP_HI);

    // Prescaled mtime counter, software writes, compare register and registered irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            pre_r      <= '0;
            irq_r      <= 1'b0;
        end else begin
            // Compare uses the values held before this edge's updates.
            irq_r <= (mtime_r >= mtimecmp_r);
            // A software write to either half suppresses the tick and restarts the prescaler.
            if (mt_lo_wr_s) begin
                mtime_r[31:0] <= merge_bytes(mtime_r[31:0], memory_data__write_data,
                                             memory_data__write_enable);
                pre_r         <= '0;
            end else if (mt_hi_wr_s) begin
                mtime_r[63:32] <= merge_bytes(mtime_r[63:32], memory_data__write_data,
                                              memory_data__write_enable);
                pre_r          <= '0;
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
                pre_r   <= '0;
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
            if (cmp_lo_wr_s) begin
                mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], memory_data__write_data,
                                                memory_data__write_enable);
            end
            if (cmp_hi_wr_s) begin
                mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], memory_data__write_data,
                                                 memory_data__write_enable);
            end
        end
    end

    assign timer_irq = irq_r;

    // ------------------------------------------------------------------
    // UART TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             ovf_set_s;
    logic             ovf_clr_s;

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == '0);
    assign push_s    = mmio_wr_s && (word_addr_s == ADDR_UART_TX) &&
                       memory_data__write_enable[0];
    assign pop_s     = !empty_s && uart_tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovf_set_s = push_s && full_s && !pop_s;
    assign ovf_clr_s = mmio_wr_s && (word_addr_s == ADDR_UART_STATUS) &&
                       memory_data__write_enable[0] && memory_data__write_data[2];

    // FIFO storage; entries beyond count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_r[wr_ptr_r] <= memory_data__write_data[7:0];
        end
    end

    // FIFO pointers, exact occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            // Set has priority over a clear in the same cycle.
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign uart_tx_valid = !empty_s;
    assign uart_tx_data  = fifo_r[rd_ptr_r];

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] count_ext_s;
    logic [3:0]  count_disp_s;
    logic [31:0] status_s;

    assign count_ext_s  = 32'(count_r);
    assign count_disp_s = (count_ext_s > 32'd15) ? 4'hF : count_ext_s[3:0];
    assign status_s     = {24'd0, count_disp_s, 1'b0, overflow_r, empty_s, full_s};

    // Zero-latency read data selected purely by address and current state.
    always_comb begin
        memory_data__read_data = 32'd0;
        if (ram_hit_s) begin
            memory_data__read_data = mem_r[ram_idx_s];
        end else begin
            case (word_addr_s)
                ADDR_MTIME_LO:    memory_data__read_data = mtime_r[31:0];
                ADDR_MTIME_HI:    memory_data__read_data = mtime_r[63:32];
                ADDR_MTIMECMP_LO: memory_data__read_data = mtimecmp_r[31:0];
                ADDR_MTIMECMP_HI: memory_data__read_data = mtimecmp_r[63:32];
                ADDR_UART_STATUS: memory_data__read_data = status_s;
                default:          memory_data__read_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: a RAM/decode vector table followed by
// hand-written sequences for the timer, interrupt, FIFO and reset corner cases.
// Two instances share stimulus: one with TIMER_DIV=4, one with TIMER_DIV=1.
module tb_data_mem_mmio;

    localparam logic [31:0] A_MTIME_LO  = 32'h8000_0000;
    localparam logic [31:0] A_MTIME_HI  = 32'h8000_0004;
    localparam logic [31:0] A_CMP_LO    = 32'h8000_0008;
    localparam logic [31:0] A_CMP_HI    = 32'h8000_000C;
    localparam logic [31:0] A_UART_TX   = 32'h8000_0010;
    localparam logic [31:0] A_UART_STAT = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        ready;
    logic [31:0] rd_a, rd_b;
    logic        valid_a, valid_b;
    logic [7:0]  data_a, data_b;
    logic        irq_a, irq_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .TIMER_DIV(4)) u_dut_div4 (
        .clk                       (clk),
        .reset                     (reset),
        .memory_data__address      (addr),
        .memory_data__write_data   (wdata),
        .memory_data__write_enable (we),
        .memory_data__read_data    (rd_a),
        .uart_tx_valid             (valid_a),
        .uart_tx_data              (data_a),
        .uart_tx_ready             (ready),
        .timer_irq                 (irq_a)
    );

    data_mem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .TIMER_DIV(1)) u_dut_div1 (
        .clk                       (clk),
        .reset                     (reset),
        .memory_data__address      (addr),
        .memory_data__write_data   (wdata),
        .memory_data__write_enable (we),
        .memory_data__read_data    (rd_b),
        .uart_tx_valid             (valid_b),
        .uart_tx_data              (data_b),
        .uart_tx_ready             (ready),
        .timer_irq                 (irq_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock with the given access; strobes drop right after the edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        addr  = a;
        wdata = d;
        we    = w;
        @(posedge clk);
        #1;
        we = 4'b0000;
    endtask

    // Present a read address and let the combinational path settle.
    task automatic rd(input logic [31:0] a);
        addr = a;
        we   = 4'b0000;
        #1;
    endtask

    task automatic do_reset();
        we    = 4'b0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;
        addr  = 32'd0;
        wdata = 32'd0;
        we    = 4'b0000;
        ready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // ---------------- RAM / decode table (DUT with TIMER_DIV=1) ----------------
        vecs[0]  = '{32'h8000_0008, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF};
        vecs[1]  = '{32'h8000_000C, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h8000_0014, 32'h0, 4'b0000, 1'b1, 32'h0000_0002};
        vecs[3]  = '{32'h0000_0010, 32'hAABB_CCDD, 4'b1111, 1'b0, 32'h0};
        vecs[4]  = '{32'h0000_0010, 32'h0000_0011, 4'b0001, 1'b1, 32'hAABB_CCDD};
        vecs[5]  = '{32'h0000_0010, 32'h0, 4'b0000, 1'b1, 32'hAABB_CC11};
        vecs[6]  = '{32'h0000_0000, 32'h1234_5678, 4'b1111, 1'b0, 32'h0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_AB00, 4'b0010, 1'b1, 32'h1234_5678};
        vecs[8]  = '{32'h0000_0003, 32'h0, 4'b0000, 1'b1, 32'h1234_AB78};
        vecs[9]  = '{32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
        vecs[10] = '{32'h0000_1000, 32'h0, 4'b0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{32'h0000_0000, 32'h0, 4'b0000, 1'b1, 32'h1234_AB78};
        vecs[12] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0};
        vecs[13] = '{32'h0000_0FFC, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D};
        vecs[14] = '{32'h8000_0010, 32'h0, 4'b0000, 1'b1, 32'h0000_0000};
        vecs[15] = '{32'h8000_0020, 32'h0, 4'b0000, 1'b1, 32'h0000_0000};
        vecs[16] = '{32'h0000_0010, 32'hFFEE_DDCC, 4'b0101, 1'b1, 32'hAABB_CC11};

        for (int i = 0; i < 17; i++) begin
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            we    = vecs[i].we;
            #2;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), {32'd0, rd_b}, {32'd0, vecs[i].exp});
            end
            @(posedge clk);
            #1;
            we = 4'b0000;
        end
        rd(32'h0000_0010);
        check("ram_lane_0101", {32'd0, rd_b}, {32'd0, 32'hAAEE_CCCC});

        // ---------------- Timer with TIMER_DIV=4 ----------------
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        rd(A_MTIME_LO);
        check("div4_mtime_after8", {32'd0, rd_a}, 64'd2);
        cyc(A_MTIME_LO, 32'hFFFF_FFFF, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        rd(A_MTIME_LO);
        check("div4_lo_before_carry", {32'd0, rd_a}, {32'd0, 32'hFFFF_FFFF});
        @(posedge clk);
        #1;
        rd(A_MTIME_HI);
        check("div4_hi_carry", {32'd0, rd_a}, 64'd1);
        rd(A_MTIME_LO);
        check("div4_lo_wrapped", {32'd0, rd_a}, 64'd0);

        // ---------------- Compare interrupt with TIMER_DIV=1 ----------------
        do_reset();
        cyc(A_CMP_HI, 32'd0, 4'b1111);
        cyc(A_CMP_LO, 32'd20, 4'b1111);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            rd(A_MTIME_LO);
            if (rd_b == 32'd20) begin
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("irq_mtime_reached_20", {63'd0, hit}, 64'd1);
        check("irq_low_at_20", {63'd0, irq_b}, 64'd0);
        @(posedge clk);
        #1;
        check("irq_rises", {63'd0, irq_b}, 64'd1);
        cyc(A_CMP_LO, 32'hFFFF_FFFF, 4'b1111);
        check("irq_held_on_lo_write", {63'd0, irq_b}, 64'd1);
        cyc(A_CMP_HI, 32'hFFFF_FFFF, 4'b1111);
        check("irq_drops", {63'd0, irq_b}, 64'd0);

        // ---------------- FIFO fill and overflow ----------------
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc(A_UART_TX, 32'h41 + 32'(i), 4'b0001);
        end
        rd(A_UART_STAT);
        check("fifo_full_status", {32'd0, rd_b}, 64'h85);
        check("fifo_head_41", {56'd0, data_b}, 64'h41);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("drain_valid%0d", i), {63'd0, valid_b}, 64'd1);
            check($sformatf("drain_data%0d", i), {56'd0, data_b}, 64'h41 + 64'(i));
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("drained_valid", {63'd0, valid_b}, 64'd0);
        rd(A_UART_STAT);
        check("drained_status", {32'd0, rd_b}, 64'h06);

        // ---------------- Full + push + pop, then clear overflow ----------------
        for (int i = 0; i < 8; i++) begin
            cyc(A_UART_TX, 32'h50 + 32'(i), 4'b0001);
        end
        rd(A_UART_STAT);
        check("refill_status", {32'd0, rd_b}, 64'h85);
        ready = 1'b1;
        cyc(A_UART_TX, 32'h58, 4'b0001);
        ready = 1'b0;
        rd(A_UART_STAT);
        check("push_pop_full_status", {32'd0, rd_b}, 64'h85);
        check("push_pop_head", {56'd0, data_b}, 64'h51);
        cyc(A_UART_STAT, 32'h4, 4'b0001);
        rd(A_UART_STAT);
        check("ovf_cleared", {32'd0, rd_b}, 64'h81);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("pp_data%0d", i), {56'd0, data_b}, 64'h51 + 64'(i));
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("pp_empty", {63'd0, valid_b}, 64'd0);

        // ---------------- Reset mid-operation ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(A_UART_TX, 32'h61 + 32'(i), 4'b0001);
        end
        cyc(A_CMP_HI, 32'd0, 4'b1111);
        cyc(A_CMP_LO, 32'd0, 4'b1111);
        cyc(A_MTIME_LO, 32'd100, 4'b1111);
        rd(A_MTIME_LO);
        check("pre_reset_mtime", {32'd0, rd_b}, 64'd100);
        check("pre_reset_irq", {63'd0, irq_b}, 64'd1);
        check("pre_reset_valid", {63'd0, valid_b}, 64'd1);
        addr  = 32'h0000_0024;
        wdata = 32'h1234_5678;
        we    = 4'b1111;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 4'b0000;
        check("rst_valid", {63'd0, valid_b}, 64'd0);
        check("rst_irq", {63'd0, irq_b}, 64'd0);
        rd(A_MTIME_LO);
        check("rst_mtime", {32'd0, rd_b}, 64'd0);
        rd(A_UART_STAT);
        check("rst_status", {32'd0, rd_b}, 64'h02);
        rd(A_CMP_LO);
        check("rst_cmp_lo", {32'd0, rd_b}, {32'd0, 32'hFFFF_FFFF});
        rd(32'h0000_0010);
        check("rst_ram_kept", {32'd0, rd_b}, {32'd0, 32'hAAEE_CCCC});
        rd(32'h0000_0024);
        check("rst_ram_write", {32'd0, rd_b}, {32'd0, 32'h1234_5678});
        addr  = A_UART_TX;
        wdata = 32'h77;
        we    = 4'b0001;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 4'b0000;
        check("rst_push_ignored", {63'd0, valid_b}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
